// File: rtl/mem_channel_responder_if.sv
// mem_channel_responder_if: per-channel read/write valid/ready bus between the GPU (master) and the memory responder (slave)
interface mem_channel_responder_if #(
  parameter int CHANNELS = 4,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
);
  logic [CHANNELS-1:0] read_valid, read_ready, write_valid, write_ready;
  logic [CHANNELS*ADDR_BITS-1:0] read_address, write_address;
  logic [CHANNELS*DATA_BITS-1:0] read_data, write_data;
  modport master (
    output read_valid, read_address, write_valid, write_address, write_data,
    input  read_ready, read_data, write_ready
  );
  modport slave (
    input  read_valid, read_address, write_valid, write_address, write_data,
    output read_ready, read_data, write_ready
  );
endinterface

// File: rtl/mem_channel_responder.sv
// mem_channel_responder: fixed-latency multi-channel memory responder; ports clk, reset (sync active-low), bus (slave), bd_we/bd_addr/bd_wdata/bd_rdata backdoor
module mem_channel_responder #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int CHANNELS = 4,
  parameter int LATENCY = 2,
  parameter int WRITABLE = 1
) (
  input  logic clk,
  input  logic reset,
  mem_channel_responder_if.slave bus,
  input  logic bd_we,
  input  logic [ADDR_BITS-1:0] bd_addr,
  input  logic [DATA_BITS-1:0] bd_wdata,
  output logic [DATA_BITS-1:0] bd_rdata
);
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];
  logic [1:0] state [CHANNELS];
  logic [3:0] cnt [CHANNELS];
  logic [ADDR_BITS-1:0] addr_q [CHANNELS];
  logic [DATA_BITS-1:0] data_q [CHANNELS];
  logic [CHANNELS-1:0] op_wr, dropped, rr_q, wr_q, commit, valid_o;
  logic [CHANNELS*DATA_BITS-1:0] rd_q;

  always_comb begin
    commit = '0;
    valid_o = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      valid_o[c] = op_wr[c] ? bus.write_valid[c] : bus.read_valid[c];
      commit[c] = reset && state[c] == S_WAIT && cnt[c] == 4'd0 && op_wr[c];
    end
  end

  always_ff @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_wdata;
    for (int c = 0; c < CHANNELS; c++)
      if (commit[c]) mem[addr_q[c]] <= data_q[c];
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++)
      if (!reset) begin
        state[c] <= S_IDLE;
        cnt[c] <= '0;
        op_wr[c] <= 1'b0;
        dropped[c] <= 1'b0;
        rr_q[c] <= 1'b0;
        wr_q[c] <= 1'b0;
        rd_q[c*DATA_BITS +: DATA_BITS] <= '0;
      end else begin
        case (state[c])
          S_IDLE:
            if (bus.read_valid[c]) begin
              state[c] <= S_WAIT;
              cnt[c] <= LAT_M1;
              op_wr[c] <= 1'b0;
              dropped[c] <= 1'b0;
              addr_q[c] <= bus.read_address[c*ADDR_BITS +: ADDR_BITS];
            end else if (bus.write_valid[c] && WRITABLE != 0) begin
              state[c] <= S_WAIT;
              cnt[c] <= LAT_M1;
              op_wr[c] <= 1'b1;
              dropped[c] <= 1'b0;
              addr_q[c] <= bus.write_address[c*ADDR_BITS +: ADDR_BITS];
              data_q[c] <= bus.write_data[c*DATA_BITS +: DATA_BITS];
            end
          S_WAIT: begin
            cnt[c] <= cnt[c] == 4'd0 ? 4'd0 : cnt[c] - 4'd1;
            dropped[c] <= dropped[c] | ~valid_o[c];
            if (cnt[c] == 4'd0) begin
              state[c] <= S_RESP;
              wr_q[c] <= op_wr[c];
              rr_q[c] <= ~op_wr[c];
              if (!op_wr[c]) rd_q[c*DATA_BITS +: DATA_BITS] <= mem[addr_q[c]];
            end
          end
          S_RESP:
            if (!valid_o[c] || dropped[c]) begin
              state[c] <= S_IDLE;
              rr_q[c] <= 1'b0;
              wr_q[c] <= 1'b0;
              rd_q[c*DATA_BITS +: DATA_BITS] <= '0;
            end
          default: state[c] <= S_IDLE;
        endcase
      end
  end

  assign bus.read_ready = rr_q;
  assign bus.write_ready = (WRITABLE != 0) ? wr_q : '0;
  assign bus.read_data = rd_q;
  assign bd_rdata = mem[bd_addr];
endmodule

// File: doc/mem_channel_responder.md
Name: mem_channel_responder

Overview:
- Synthesizable multi-channel memory responder for the target side of the GPU's program/data memory valid/ready interface.
- Replaces the behavioural testbench memory so benches and FPGA builds can drive `gpu` against real RTL.
- Holds a 2^ADDR_BITS x DATA_BITS array and services per-channel read/write requests with a fixed, programmable latency.
- Has a backdoor port for preload and result checking.

Parameters:
- ADDR_BITS, 8, address width; array depth = 2^ADDR_BITS.
- DATA_BITS, 8, word width (16 for program memory).
- CHANNELS, 4, number of independent request channels.
- LATENCY, 2, cycles from request acceptance to ready assertion; legal range 1..15.
- WRITABLE, 1, 0 = read-only instance; write ports ignored, write_ready tied 0.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- read_valid  in  CHANNELS  per-channel read request.
- read_address  in  CHANNELS*ADDR_BITS  per-channel read address.
- read_ready  out  CHANNELS  per-channel read response strobe.
- read_data  out  CHANNELS*DATA_BITS  per-channel read data, valid while read_ready is high.
- write_valid  in  CHANNELS  per-channel write request.
- write_address  in  CHANNELS*ADDR_BITS  per-channel write address.
- write_data  in  CHANNELS*DATA_BITS  per-channel write data.
- write_ready  out  CHANNELS  per-channel write acknowledge.
- bd_we  in  1  backdoor write enable.
- bd_addr  in  ADDR_BITS  backdoor address.
- bd_wdata  in  DATA_BITS  backdoor write data.
- bd_rdata  out  DATA_BITS  combinational backdoor read of array[bd_addr].

Behaviour:
- Reset: sampled at posedge clk while reset==0.
  - All channel FSMs go to IDLE; read_ready=0, write_ready=0, read_data=0, latency counters=0.
  - Array contents are NOT cleared.
- Per-channel FSM states:
  - IDLE: if read_valid is sampled high, latch address, counter=LATENCY-1, op=READ, go to WAIT. Else if write_valid (and WRITABLE) is sampled high, latch address and data, op=WRITE, go to WAIT. Read wins when both are high; the write stays pending and is accepted on the next IDLE visit.
  - WAIT: decrement the counter each cycle. On the edge where counter==0, go to RESP:
    - READ: read_data <= array[addr], read_ready <= 1.
    - WRITE: array[addr] <= data, write_ready <= 1.
    - Net effect: valid sampled at edge t gives ready high after edge t+LATENCY.
  - RESP: hold ready and read_data stable while the originating valid stays high. On the first edge where valid is sampled low, drop ready, clear read_data to 0, go to IDLE. No new request is accepted on that same edge (minimum 1 idle cycle between transactions).
- Address and data are captured at acceptance. Changes on address/data inputs during WAIT/RESP are ignored.
- Read data is taken from the array at response time, so a write committed by another channel during WAIT is visible.
- Simultaneous array writes on the same edge:
  - Between channels: the highest-numbered channel wins.
  - Any channel write beats bd_we.
  - Writes to distinct addresses all commit.
- bd_we writes the array on posedge regardless of reset state. The backdoor never touches channel FSMs.
- If valid drops during WAIT (protocol violation): the transaction still completes; ready pulses for exactly 1 cycle; a write still commits.
- Reset asserted mid-transaction: the FSM aborts to IDLE next edge and ready clears. A write commits only if its commit edge precedes the reset edge.
- Address arithmetic: no wrap logic needed; addresses index the array directly at full ADDR_BITS.
- Channels are fully independent; there is no arbitration stall.

Test Plan:
- Reset clears outputs: preload array[5]=0x2A via backdoor; pulse reset low 1 cycle -> read_ready=0, write_ready=0, read_data=0; bd_rdata at addr 5 still 0x2A.
- Read latency: LATENCY=2; ch0 read_valid=1, addr 3, array[3]=7, sampled at edge t -> read_ready=1 and read_data=7 after edge t+2. Hold valid 3 more cycles -> ready stays high. Drop valid -> ready=0 next edge.
- Parallel channels: ch0..ch3 write 16..19 with data 0,2,4,6 in the same cycle -> all write_ready assert together. Backdoor reads 16..19 return 0,2,4,6.
- Write collision: ch1 and ch3 write addr 20 with 0x11 and 0x33 in the same cycle, bd_we writes 0x55 on the commit edge -> array[20]=0x33.
- Read/write both valid on ch2 in IDLE: read addr 0 serviced first. The write is accepted after the read completes plus 1 idle cycle; write_ready follows LATENCY later.
- Mid-transaction reset and early valid drop:
  - ch0 write accepted, reset low during WAIT -> array unchanged, write_ready never asserts.
  - Separately, drop read_valid during WAIT -> read_ready pulses exactly 1 cycle, then IDLE.
